acc_buffer: RTL and testbench
=============================

ACC_BUFFER -- requirements
Module: acc_buffer

Interface
REQ-001 SHALL have parameter ARRAY_DIM, default 16: number of 32-bit lanes per word.
REQ-002 SHALL have parameter ACC_W, default 32: lane width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024: number of words; address width is 10 bits.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port acc_enable  input  1  write strobe, one word per cycle.
REQ-007 SHALL have port acc_clear  input  1  when set with acc_enable, overwrite instead of add.
REQ-008 SHALL have port acc_addr  input  10  target word address.
REQ-009 SHALL have port pe_acc_out  input  ARRAY_DIM*ACC_W  lane vector; lane i is bits [i*32+31:i*32].
REQ-010 SHALL have port drain_start  input  1  pulse that requests readout of words 0..drain_count-1.
REQ-011 SHALL have port drain_count  input  11  number of words to drain, 0..1024, sampled on drain_start.
REQ-012 SHALL have port out_valid  output  1  out_data/out_addr are valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the word when out_valid&&out_ready.
REQ-014 SHALL have port out_addr  output  10  address of the presented word.
REQ-015 SHALL have port out_data  output  ARRAY_DIM*ACC_W  presented word.
REQ-016 SHALL have port busy  output  1  high from accepted drain_start until drain_done.
REQ-017 SHALL have port drain_done  output  1  one-cycle pulse when the drain completes.
REQ-018 SHALL have port sat_flag  output  1  sticky flag: a lane saturated since the last reset or drain_start.
REQ-019 SHALL have port err_flag  output  1  sticky flag: acc_enable was seen while busy.

Function
REQ-020 Update SHALL be a 2-stage read-modify-write: stage 1 registers addr/data/clear and reads memory; stage 2 writes memory; a word is committed 2 cycles after acc_enable is sampled.
REQ-021 If clear is set, the committed lane SHALL equal the pe_acc_out lane; otherwise it SHALL equal the signed stored lane plus the signed input lane.
REQ-022 Addition SHALL saturate per lane to 0x7FFFFFFF or 0x80000000, and any saturation SHALL set sat_flag.
REQ-023 When the stage-1 address equals the stage-2 address, the stage-2 result SHALL be forwarded, so back-to-back updates to one address are exact.
REQ-024 FSM states SHALL be S_IDLE, S_FLUSH, S_FETCH, S_PRESENT and S_DONE.
REQ-025 In S_IDLE, drain_start SHALL latch drain_count and clear sat_flag, then go to S_FLUSH.
REQ-026 S_FLUSH SHALL wait until the RMW pipeline is empty, then go to S_FETCH, or to S_DONE when the latched count is 0.
REQ-027 S_FETCH SHALL issue a memory read for the current address, then go to S_PRESENT.
REQ-028 S_PRESENT SHALL hold out_valid=1 with stable out_data and out_addr until out_ready.
REQ-029 On handshake, S_PRESENT SHALL advance to the next address and go to S_FETCH, or go to S_DONE after the last word.
REQ-030 S_DONE SHALL pulse drain_done for one cycle and return to S_IDLE; busy SHALL fall in the same cycle.
REQ-031 acc_enable while busy SHALL be ignored (no memory change) and SHALL set err_flag.
REQ-032 drain_start while busy SHALL be ignored.
REQ-033 Simultaneous acc_enable and drain_start in S_IDLE SHALL accept both; the update SHALL complete before the drain reads memory.
REQ-034 Memory contents SHALL be undefined after power-up; the first write to each address uses acc_clear=1.

Reset
REQ-035 rst SHALL force S_IDLE and set out_valid=0, out_addr=0, out_data=0, busy=0, drain_done=0, sat_flag=0, err_flag=0, and empty the RMW pipeline.
REQ-036 rst mid-drain SHALL abort the drain with no drain_done pulse; memory contents SHALL be retained.

Structure
REQ-037 The shared package SHALL hold ARRAY_DIM, ACC_W, the 10-bit address width, the FSM state encodings and the saturating-add constants.
REQ-038 There SHALL be one sub-module, acc_lane_sat_add: a combinational ACC_W signed saturating adder with an overflow output, instantiated ARRAY_DIM times.

Verification
REQ-039 Clear-then-add: addr 5, lanes=3 with clear, then addr 5, lanes=4 -> drain of count 6 returns word 5, all lanes = 7.
REQ-040 Back-to-back hazard: addr 9 on 3 consecutive cycles (clear 1, then 2, then 3) -> lanes = 6.
REQ-041 Saturation: lane 0 = 0x7FFFFFF0 with clear, then +0x20 -> lane 0 = 0x7FFFFFFF, sat_flag = 1.
REQ-042 Backpressure: drain count 3 with out_ready low for 4 cycles on word 1 -> out_data is stable, addresses 0,1,2 appear in order, drain_done is a single pulse.
REQ-043 Edge cases: drain count 0 -> drain_done two cycles later with no out_valid; acc_enable during drain -> err_flag = 1 and memory unchanged.
REQ-044 Reset mid-drain: rst during S_PRESENT -> outputs take reset values, and a new drain returns the prior memory contents.

Source files
------------

// File: rtl/acc_buffer_pkg.sv
// Shared sizing, FSM encoding and saturation limits for the accumulation buffer.
package acc_buffer_pkg;
    localparam int ARRAY_DIM = 16;
    localparam int ACC_W     = 32;
    localparam int ADDR_W    = 10;
    localparam int CNT_W     = ADDR_W + 1;

    localparam logic [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_e;
endpackage

// File: rtl/acc_lane_sat_add.sv
// One lane of signed saturating addition; ovf_o flags a clamped result.
module acc_lane_sat_add
    import acc_buffer_pkg::*;
#(
    parameter int             W     = ACC_W,
    parameter logic [W-1:0]   MAX_V = SAT_POS,
    parameter logic [W-1:0]   MIN_V = SAT_NEG
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);
    logic [W-1:0] raw;

    always_comb begin
        raw   = a_i + b_i;
        // Overflow only when both operands share a sign the wrapped sum lost.
        ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
        sum_o = ovf_o ? (a_i[W-1] ? MIN_V : MAX_V) : raw;
    end
endmodule

// File: rtl/acc_buffer.sv
// Accumulation buffer: 2-stage read-modify-write update path plus a handshaked drain engine.
module acc_buffer
    import acc_buffer_pkg::*;
#(
    parameter int ARRAY_DIM = acc_buffer_pkg::ARRAY_DIM,
    parameter int ACC_W     = acc_buffer_pkg::ACC_W,
    parameter int DEPTH     = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       acc_enable,
    input  logic                       acc_clear,
    input  logic [ADDR_W-1:0]          acc_addr,
    input  logic [ARRAY_DIM*ACC_W-1:0] pe_acc_out,
    input  logic                       drain_start,
    input  logic [CNT_W-1:0]           drain_count,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [ARRAY_DIM*ACC_W-1:0] out_data,
    output logic                       busy,
    output logic                       drain_done,
    output logic                       sat_flag,
    output logic                       err_flag
);
    localparam logic [ACC_W-1:0] LANE_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] LANE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef logic [ARRAY_DIM-1:0][ACC_W-1:0] word_t;

    word_t             mem [DEPTH];
    state_e            state_q, state_d;
    logic [1:0]        vld_pipe_q;
    logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
    logic              s1_clr_q;
    word_t             s1_data_q, s2_data_q, rd_q;
    word_t             fwd, sum, result;
    logic [ARRAY_DIM-1:0] ovf;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d, err_q;
    logic              acc_fire, start_fire, sat_hit, rd_en;

    assign busy       = (state_q == S_FLUSH) || (state_q == S_FETCH) || (state_q == S_PRESENT);
    assign out_valid  = (state_q == S_PRESENT);
    assign drain_done = (state_q == S_DONE);
    assign out_addr   = addr_q;
    assign out_data   = rd_q;
    assign sat_flag   = sat_q;
    assign err_flag   = err_q;

    assign acc_fire   = acc_enable && !busy;
    assign start_fire = drain_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // One read port: updates read only when idle, the drain only in S_FETCH.
    assign rd_en   = acc_fire || (state_q == S_FETCH);
    assign rd_addr = (state_q == S_FETCH) ? addr_q : acc_addr;

    // The word written on the same edge as our read is still in stage 2.
    assign fwd = (vld_pipe_q[1] && (s2_addr_q == s1_addr_q)) ? s2_data_q : rd_q;

    for (genvar g = 0; g < ARRAY_DIM; g++) begin : g_lane
        acc_lane_sat_add #(
            .W    (ACC_W),
            .MAX_V(LANE_MAX),
            .MIN_V(LANE_MIN)
        ) u_lane (
            .a_i  (fwd[g]),
            .b_i  (s1_data_q[g]),
            .sum_o(sum[g]),
            .ovf_o(ovf[g])
        );
    end

    assign result  = s1_clr_q ? s1_data_q : sum;
    assign sat_hit = vld_pipe_q[0] && !s1_clr_q && (|ovf);
    assign sat_d   = start_fire ? 1'b0 : (sat_q | sat_hit);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (drain_start) begin
                    cnt_d   = drain_count;
                    addr_d  = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (vld_pipe_q == 2'b00) state_d = (cnt_q == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_d = S_PRESENT;
            S_PRESENT: begin
                if (out_ready) begin
                    if (({1'b0, addr_q} + CNT_W'(1)) == cnt_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= {vld_pipe_q[0], acc_fire};
            sat_q      <= sat_d;
            err_q      <= err_q | (acc_enable && busy);
            if (rd_en) rd_q <= mem[rd_addr];
        end
    end

    // Storage and pipeline payload carry no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && vld_pipe_q[0]) mem[s1_addr_q] <= result;
        if (acc_fire) begin
            s1_addr_q <= acc_addr;
            s1_data_q <= pe_acc_out;
            s1_clr_q  <= acc_clear;
        end
        if (vld_pipe_q[0]) begin
            s2_addr_q <= s1_addr_q;
            s2_data_q <= result;
        end
    end
endmodule

// File: tb/tb_acc_buffer.sv
// Directed self-checking bench for acc_buffer.
module tb_acc_buffer;
    typedef logic [15:0][31:0] word_t;

    logic        clk = 1'b0;
    logic        rst, acc_enable, acc_clear, drain_start, out_ready;
    logic [9:0]  acc_addr;
    logic [10:0] drain_count;
    logic [511:0] pe_acc_out;
    logic        out_valid, busy, drain_done, sat_flag, err_flag;
    logic [9:0]  out_addr;
    logic [511:0] out_data;

    int checks = 0;
    int failures = 0;

    word_t      exp_mem [16];
    word_t      cap_data [$];
    logic [9:0] cap_addr [$];
    int         done_pulses, unstable, valid_cycles;
    bit         timed_out;

    acc_buffer dut (
        .clk(clk), .rst(rst), .acc_enable(acc_enable), .acc_clear(acc_clear),
        .acc_addr(acc_addr), .pe_acc_out(pe_acc_out), .drain_start(drain_start),
        .drain_count(drain_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .drain_done(drain_done),
        .sat_flag(sat_flag), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    function automatic word_t mk(input logic [31:0] v);
        word_t w;
        for (int i = 0; i < 16; i++) w[i] = v;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_write(input logic [9:0] a, input word_t d, input bit clr);
        acc_enable = 1'b1; acc_addr = a; pe_acc_out = d; acc_clear = clr;
        tick();
        acc_enable = 1'b0; acc_clear = 1'b0;
    endtask

    // Runs a drain, capturing accepted words; optionally stalls one word.
    task automatic run_drain(input int count, input int stall_word, input int stall_cycles);
        int    stall_left;
        int    tail;
        word_t held;
        cap_data.delete(); cap_addr.delete();
        done_pulses = 0; unstable = 0; valid_cycles = 0; timed_out = 1'b1;
        stall_left = stall_cycles; tail = -1; held = '0;
        drain_count = 11'(count); drain_start = 1'b1; out_ready = 1'b1;
        tick();
        drain_start = 1'b0; acc_enable = 1'b0; acc_clear = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (drain_done) done_pulses++;
            out_ready = 1'b1;
            if (out_valid) begin
                valid_cycles++;
                if (cap_data.size() == stall_word && stall_left > 0) begin
                    if (stall_left == stall_cycles) held = out_data;
                    else if (out_data !== held) unstable++;
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    cap_data.push_back(out_data);
                    cap_addr.push_back(out_addr);
                end
            end
            if (drain_done && tail < 0) tail = 2;
            if (tail == 0) begin
                timed_out = 1'b0;
                break;
            end
            if (tail > 0) tail--;
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_addr !== 10'd0) begin failures++; $display("FAIL reset_out_addr got=%0h exp=0", out_addr); end
        checks++; if (out_data !== 512'd0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (drain_done !== 1'b0) begin failures++; $display("FAIL reset_drain_done got=%b exp=0", drain_done); end
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat_flag got=%b exp=0", sat_flag); end
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_err_flag got=%b exp=0", err_flag); end
        rst = 1'b0;
        tick();
    endtask

    task automatic init_mem();
        for (int a = 0; a < 16; a++) begin
            exp_mem[a] = mk(32'(a * 256));
            acc_write(10'(a), exp_mem[a], 1'b1);
        end
        repeat (2) tick();
    endtask

    task automatic test_clear_add();
        acc_write(10'd5, mk(32'd3), 1'b1);
        tick();
        acc_write(10'd5, mk(32'd4), 1'b0);
        exp_mem[5] = mk(32'd7);
        run_drain(6, -1, 0);
        checks++; if (cap_data.size() != 6 || timed_out) begin failures++; $display("FAIL clear_add_count got=%0d exp=6", cap_data.size()); end
        for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_mem[i] || cap_addr[i] !== 10'(i)) begin
                failures++; $display("FAIL clear_add_word%0d got=%0h@%0d exp=%0h", i, cap_data[i], cap_addr[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        acc_write(10'd9, mk(32'd1), 1'b1);
        acc_write(10'd9, mk(32'd2), 1'b0);
        acc_write(10'd9, mk(32'd3), 1'b0);
        acc_write(10'd11, mk(32'd10), 1'b1);
        acc_write(10'd12, mk(32'd1), 1'b1);
        acc_write(10'd11, mk(32'd5), 1'b0);
        exp_mem[9] = mk(32'd6); exp_mem[11] = mk(32'd15); exp_mem[12] = mk(32'd1);
        run_drain(13, -1, 0);
        checks++; if (cap_data.size() != 13) begin failures++; $display("FAIL b2b_count got=%0d exp=13", cap_data.size()); end
        else begin
            checks++; if (cap_data[9] !== exp_mem[9]) begin failures++; $display("FAIL b2b_word9 got=%0h exp=%0h", cap_data[9], exp_mem[9]); end
            checks++; if (cap_data[11] !== exp_mem[11]) begin failures++; $display("FAIL gap1_word11 got=%0h exp=%0h", cap_data[11], exp_mem[11]); end
            checks++; if (cap_data[12] !== exp_mem[12]) begin failures++; $display("FAIL gap1_word12 got=%0h exp=%0h", cap_data[12], exp_mem[12]); end
        end
    endtask

    task automatic test_saturation();
        word_t d;
        d = mk(32'd1); d[0] = 32'h7FFF_FFF0;
        acc_write(10'd2, d, 1'b1);
        d = mk(32'hFFFF_FFFF); d[0] = 32'h8000_0010;
        acc_write(10'd3, d, 1'b1);
        repeat (2) tick();
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_after_clear got=%b exp=0", sat_flag); end
        d = mk(32'd1); d[0] = 32'h0000_0020;
        acc_write(10'd2, d, 1'b0);
        d = mk(32'hFFFF_FFFF); d[0] = 32'hFFFF_FFE0;
        acc_write(10'd3, d, 1'b0);
        repeat (2) tick();
        checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_flag_set got=%b exp=1", sat_flag); end
        exp_mem[2] = mk(32'd2); exp_mem[2][0] = 32'h7FFF_FFFF;
        exp_mem[3] = mk(32'hFFFF_FFFE); exp_mem[3][0] = 32'h8000_0000;
        run_drain(4, -1, 0);
        checks++; if (cap_data.size() != 4) begin failures++; $display("FAIL sat_count got=%0d exp=4", cap_data.size()); end
        else begin
            checks++; if (cap_data[2] !== exp_mem[2]) begin failures++; $display("FAIL sat_pos_word got=%0h exp=%0h", cap_data[2], exp_mem[2]); end
            checks++; if (cap_data[3] !== exp_mem[3]) begin failures++; $display("FAIL sat_neg_word got=%0h exp=%0h", cap_data[3], exp_mem[3]); end
        end
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_cleared_by_drain got=%b exp=0", sat_flag); end
    endtask

    task automatic test_backpressure();
        run_drain(3, 1, 4);
        checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
        checks++; if (cap_addr.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", cap_addr.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (cap_addr[i] !== 10'(i) || cap_data[i] !== exp_mem[i]) begin
                    failures++; $display("FAIL bp_word%0d got=%0h@%0d exp=%0h@%0d", i, cap_data[i], cap_addr[i], exp_mem[i], i);
                end
            end
        end
        checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_pulses); end
    endtask

    task automatic test_drain_zero();
        drain_count = 11'd0; drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        checks++; if (drain_done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL zero_cycle1 got=%b%b exp=01", drain_done, busy); end
        tick();
        checks++; if (drain_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL zero_cycle2 got=%b%b%b exp=100", drain_done, busy, out_valid);
        end
        tick();
        checks++; if (drain_done !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL zero_cycle3 got=%b%b exp=00", drain_done, out_valid); end
    endtask

    task automatic test_simultaneous();
        acc_enable = 1'b1; acc_clear = 1'b1; acc_addr = 10'd4; pe_acc_out = mk(32'h44);
        exp_mem[4] = mk(32'h44);
        run_drain(5, -1, 0);
        checks++; if (cap_data.size() != 5) begin failures++; $display("FAIL simul_count got=%0d exp=5", cap_data.size()); end
        else begin
            checks++; if (cap_data[4] !== exp_mem[4]) begin failures++; $display("FAIL simul_word4 got=%0h exp=%0h", cap_data[4], exp_mem[4]); end
        end
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL simul_err got=%b exp=0", err_flag); end
    endtask

    task automatic test_err_during_drain();
        bit seen;
        drain_count = 11'd1; drain_start = 1'b1; out_ready = 1'b0;
        tick();
        drain_start = 1'b0;
        acc_write(10'd0, mk(32'hDEAD), 1'b1);
        checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL err_flag_set got=%b exp=1", err_flag); end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (drain_done) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen) begin failures++; $display("FAIL err_drain_timeout got=0 exp=1"); end
        tick();
        run_drain(1, -1, 0);
        checks++; if (cap_data.size() != 1 || cap_data[0] !== exp_mem[0]) begin
            failures++; $display("FAIL err_mem_unchanged got=%0h exp=%0h", (cap_data.size() > 0) ? cap_data[0] : word_t'('0), exp_mem[0]);
        end
    endtask

    task automatic test_reset_mid_drain();
        bit seen;
        int bad;
        drain_count = 11'd4; drain_start = 1'b1; out_ready = 1'b0;
        tick();
        drain_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen) begin failures++; $display("FAIL rmid_present_timeout got=0 exp=1"); end
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || drain_done !== 1'b0) begin
            failures++; $display("FAIL rmid_ctrl got=%b%b%b exp=000", out_valid, busy, drain_done);
        end
        checks++; if (out_addr !== 10'd0 || out_data !== 512'd0) begin failures++; $display("FAIL rmid_outputs got=%0h@%0h exp=0@0", out_data, out_addr); end
        checks++; if (err_flag !== 1'b0 || sat_flag !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%b%b exp=00", err_flag, sat_flag); end
        rst = 1'b0; out_ready = 1'b1;
        bad = 0;
        repeat (3) begin
            tick();
            if (drain_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", bad); end
        run_drain(16, -1, 0);
        checks++; if (cap_data.size() != 16 || done_pulses != 1) begin
            failures++; $display("FAIL rmid_redrain got=%0d/%0d exp=16/1", cap_data.size(), done_pulses);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap_data[i] !== exp_mem[i]) begin failures++; $display("FAIL rmid_word%0d got=%0h exp=%0h", i, cap_data[i], exp_mem[i]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; acc_enable = 1'b0; acc_clear = 1'b0; acc_addr = '0; pe_acc_out = '0;
        drain_start = 1'b0; drain_count = '0; out_ready = 1'b1;
        test_reset();
        init_mem();
        test_clear_add();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_drain_zero();
        test_simultaneous();
        test_err_during_drain();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
